// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with an iterative multiply/divide sequencer and HI/LO registers.
// MUL/DIV run one bit per cycle for WIDTH cycles and stall mfhi/mflo/MDU issue while busy.
module alu_ctrl_mdu #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [2:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [WIDTH-1:0]  src1_i,
    input  logic [WIDTH-1:0]  src2_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  hi_o,
    output logic [WIDTH-1:0]  lo_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   work, work_step, prod_fix;
    logic [WIDTH-1:0]     opnd, mag1, mag2, q_fix, r_fix;
    logic [WIDTH:0]       mul_sum, div_diff;
    logic                 neg_q, neg_r;
    logic [3:0]           code;
    logic                 is_mdu, is_mv, is_mul_f, is_sgn, busy, start, last;

    always_comb begin
        code = 4'b1111;
        case (ALUOp_i)
            3'b000, 3'b011: code = 4'b0010;
            3'b001:         code = 4'b0110;
            3'b111:         code = 4'b0111;
            3'b010: begin
                case (funct_i)
                    6'h20:                      code = 4'b0010;
                    6'h22:                      code = 4'b0110;
                    6'h24:                      code = 4'b0000;
                    6'h25:                      code = 4'b0001;
                    6'h2A:                      code = 4'b0111;
                    6'h10:                      code = 4'b1000;
                    6'h12:                      code = 4'b1001;
                    6'h18, 6'h19, 6'h1A, 6'h1B: code = 4'b1110;
                    default:                    code = 4'b1111;
                endcase
            end
            default:        code = 4'b1111;
        endcase
    end

    assign ALUCtrl_o = CTRL_W'(code);

    // funct 0x18..0x1B: bit1 selects div, bit0 selects unsigned
    assign is_mdu   = (ALUOp_i == 3'b010) && (funct_i[5:2] == 4'b0110);
    assign is_mv    = (ALUOp_i == 3'b010) && ((funct_i == 6'h10) || (funct_i == 6'h12));
    assign is_mul_f = ~funct_i[1];
    assign is_sgn   = ~funct_i[0];

    assign busy    = !rst_i && ((state == S_MUL) || (state == S_DIV));
    assign start   = valid_i && is_mdu && ((state == S_IDLE) || (state == S_DONE));
    assign stall_o = valid_i && (is_mdu || is_mv) && busy;
    assign done_o  = !rst_i && (state == S_DONE);
    assign last    = (cnt == CNT_W'(WIDTH - 1));

    assign mag1 = (is_sgn && src1_i[WIDTH-1]) ? -src1_i : src1_i;
    assign mag2 = (is_sgn && src2_i[WIDTH-1]) ? -src2_i : src2_i;

    // work holds {HI-part, LO-part}: product/multiplier for MUL, remainder/quotient for DIV
    always_comb begin
        work_step = work;
        mul_sum   = '0;
        div_diff  = '0;
        if (state == S_MUL) begin
            mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
            work_step = {mul_sum, work[WIDTH-1:1]};
        end else begin
            div_diff = work[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
            if (!div_diff[WIDTH])
                work_step = {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
            else
                work_step = {work[2*WIDTH-2:0], 1'b0};
        end
    end

    assign prod_fix = neg_q ? -work_step : work_step;
    assign q_fix    = neg_q ? -work_step[WIDTH-1:0] : work_step[WIDTH-1:0];
    assign r_fix    = neg_r ? -work_step[2*WIDTH-1:WIDTH] : work_step[2*WIDTH-1:WIDTH];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (is_mul_f)
                        state_nxt = S_MUL;
                    else if (src2_i == '0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_DIV;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL, S_DIV: if (last) state_nxt = S_DONE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            cnt   <= '0;
            work  <= '0;
            opnd  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi_o  <= '0;
            lo_o  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cnt   <= '0;
                        neg_q <= is_sgn && (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                        neg_r <= is_sgn && src1_i[WIDTH-1];
                        if (is_mul_f) begin
                            opnd <= mag1;
                            work <= {{WIDTH{1'b0}}, mag2};
                        end else if (src2_i == '0) begin
                            hi_o <= src1_i;
                            lo_o <= '1;
                        end else begin
                            opnd <= mag2;
                            work <= {{WIDTH{1'b0}}, mag1};
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    work <= work_step;
                    cnt  <= cnt + CNT_W'(1);
                    if (last) begin
                        if (state == S_MUL) begin
                            hi_o <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_o <= prod_fix[WIDTH-1:0];
                        end else begin
                            hi_o <= r_fix;
                            lo_o <= q_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Directed bench for alu_ctrl_mdu: decode table sweep plus multi-cycle MDU sequences.
module tb_alu_ctrl_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, valid;
    logic [2:0]   aluop;
    logic [5:0]   funct;
    logic [W-1:0] src1, src2;
    logic [3:0]   alu_ctrl;
    logic         stall, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_ctrl_mdu #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid),
        .ALUOp_i  (aluop),
        .funct_i  (funct),
        .src1_i   (src1),
        .src2_i   (src2),
        .ALUCtrl_o(alu_ctrl),
        .stall_o  (stall),
        .done_o   (done),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    typedef struct {
        logic [5:0] f;
        logic [3:0] code;
    } funct_vec_t;

    typedef struct {
        logic [2:0] op;
        logic       use_funct;
        logic [3:0] code;
    } op_vec_t;

    funct_vec_t fvec[9];
    op_vec_t    ovec[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        valid = 1'b1;
        aluop = 3'b010;
        funct = f;
        src1  = a;
        src2  = b;
    endtask

    // Caller sits in the cycle before start edge t; cycle k is the one after edge t+k-1.
    task automatic wait_result(input string nm, input int lat,
                               input logic [W-1:0] ehi, input logic [W-1:0] elo,
                               input logic [W-1:0] old_hi, input logic [W-1:0] old_lo);
        int k;
        int stalls;
        int hold_bad;
        k = 0;
        stalls = 0;
        hold_bad = 0;
        @(posedge clk);
        #1 funct = 6'h10;
        do begin
            @(negedge clk);
            k++;
            if (!done) begin
                if (stall) stalls++;
                if (hi !== old_hi || lo !== old_lo) hold_bad++;
            end
        end while (!done && k < 40);
        check({nm, " latency"}, 64'(k), 64'(lat));
        check({nm, " stall cycles"}, 64'(stalls), 64'(lat - 1));
        check({nm, " stall in done"}, 64'(stall), 64'(0));
        if (lat > 1) check({nm, " hi/lo hold"}, 64'(hold_bad), 64'(0));
        check({nm, " hi"}, 64'(hi), 64'(ehi));
        check({nm, " lo"}, 64'(lo), 64'(elo));
    endtask

    task automatic mdu_op(input string nm, input logic [5:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic [W-1:0] old_hi, input logic [W-1:0] old_lo);
        @(negedge clk);
        issue(f, a, b);
        wait_result(nm, lat, ehi, elo, old_hi, old_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int spurious;

        fvec[0] = '{6'h20, 4'b0010};
        fvec[1] = '{6'h22, 4'b0110};
        fvec[2] = '{6'h24, 4'b0000};
        fvec[3] = '{6'h25, 4'b0001};
        fvec[4] = '{6'h2A, 4'b0111};
        fvec[5] = '{6'h10, 4'b1000};
        fvec[6] = '{6'h12, 4'b1001};
        fvec[7] = '{6'h18, 4'b1110};
        fvec[8] = '{6'h3F, 4'b1111};

        ovec[0] = '{3'b000, 1'b0, 4'b0010};
        ovec[1] = '{3'b001, 1'b0, 4'b0110};
        ovec[2] = '{3'b010, 1'b1, 4'b0000};
        ovec[3] = '{3'b011, 1'b0, 4'b0010};
        ovec[4] = '{3'b100, 1'b0, 4'b1111};
        ovec[5] = '{3'b101, 1'b0, 4'b1111};
        ovec[6] = '{3'b110, 1'b0, 4'b1111};
        ovec[7] = '{3'b111, 1'b0, 4'b0111};

        rst   = 1'b1;
        valid = 1'b0;
        aluop = 3'b000;
        funct = 6'h00;
        src1  = '0;
        src2  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset stall", 64'(stall), 64'(0));

        // Decode sweep with valid low so MDU functs do not start an operation
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 9; j++) begin
                @(negedge clk);
                aluop = ovec[i].op;
                funct = fvec[j].f;
                #1;
                check($sformatf("decode op=%0d f=%0h", ovec[i].op, fvec[j].f),
                      64'(alu_ctrl), 64'(ovec[i].use_funct ? fvec[j].code : ovec[i].code));
                check("decode no X", 64'($isunknown({alu_ctrl, stall})), 64'(0));
            end
        end

        mdu_op("multu max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 33,
               32'hFFFFFFFE, 32'h00000001, 32'h0, 32'h0);
        mdu_op("mult -7*3", 6'h18, 32'hFFFFFFF9, 32'd3, 33,
               32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000001);
        mdu_op("div -7/2", 6'h1A, 32'hFFFFFFF9, 32'd2, 33,
               32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        mdu_op("divu 100/7", 6'h1B, 32'd100, 32'd7, 33,
               32'd2, 32'd14, 32'hFFFFFFFF, 32'hFFFFFFFD);
        mdu_op("div min/-1", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 33,
               32'h0, 32'h80000000, 32'd2, 32'd14);
        mdu_op("divu 5/0", 6'h1B, 32'd5, 32'd0, 1,
               32'd5, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        mdu_op("div -5/0", 6'h1A, 32'hFFFFFFFB, 32'd0, 1,
               32'hFFFFFFFB, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF);

        // Reset sampled at edge t+10 of a running divide
        @(negedge clk);
        issue(6'h1A, 32'd100, 32'd7);
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst   = 1'b1;
        valid = 1'b1;
        funct = 6'h10;
        @(negedge clk);
        check("stall during reset", 64'(stall), 64'(0));
        check("done during reset", 64'(done), 64'(0));
        @(posedge clk);
        #1;
        rst   = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        check("post-reset hi", 64'(hi), 64'(0));
        check("post-reset lo", 64'(lo), 64'(0));
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) spurious++;
            @(negedge clk);
        end
        check("discarded op no done", 64'(spurious), 64'(0));
        check("discarded op hi/lo", 64'({hi, lo}), 64'(0));

        mdu_op("div 9/4", 6'h1A, 32'd9, 32'd4, 33, 32'd1, 32'd2, 32'h0, 32'h0);

        // Back-to-back: mult issued in the DONE cycle of a divide
        mdu_op("divu 100/7 b2b", 6'h1B, 32'd100, 32'd7, 33, 32'd2, 32'd14, 32'd1, 32'd2);
        issue(6'h18, 32'hFFFFFFF9, 32'd3);
        #1;
        check("b2b issue stall", 64'(stall), 64'(0));
        check("b2b issue done", 64'(done), 64'(1));
        wait_result("b2b mult", 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'd2, 32'd14);

        @(negedge clk);
        valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
- Parametrised successor of the single-cycle ALU control decoder.
- Keeps the combinational ALUOp/funct → ALUCtrl decode and adds a defined default for every code.
- Adds an iterative multiply/divide sequencer (mult, multu, div, divu) with HI/LO registers, a stall output and mfhi/mflo select codes.
- Sits between the main control unit / register file and the ALU; stalls the PC while a multi-cycle operation runs.

Parameters:
- WIDTH, 32, operand and HI/LO width; iterative MUL/DIV takes WIDTH cycles.
- CTRL_W, 4, ALUCtrl_o width.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  instruction in decode is valid this cycle.
- ALUOp_i  in  3  ALU operation class from main control.
- funct_i  in  6  instruction funct field.
- src1_i  in  WIDTH  rs operand (dividend / multiplicand).
- src2_i  in  WIDTH  rt operand (divisor / multiplier).
- ALUCtrl_o  out  CTRL_W  combinational ALU control code.
- stall_o  out  1  combinational; hold PC/IF-ID while high.
- done_o  out  1  one-cycle pulse when HI/LO are updated.
- hi_o  out  WIDTH  HI register (remainder / upper product).
- lo_o  out  WIDTH  LO register (quotient / lower product).

Behaviour:
- Decode (combinational):
  - ALUOp 000 or 011 → 0010 (add).
  - ALUOp 001 → 0110 (sub).
  - ALUOp 111 → 0111 (slt).
  - ALUOp 010, by funct:
    - 0x20 → 0010; 0x22 → 0110; 0x24 → 0000; 0x25 → 0001; 0x2A → 0111.
    - 0x10 mfhi → 1000; 0x12 mflo → 1001.
    - 0x18 / 0x19 / 0x1A / 0x1B → 1110 (MDU, ALU result unused).
  - Any other ALUOp or funct → 1111. No latches.
- MDU start: valid_i & ALUOp=010 & funct∈{18,19,1A,1B} & state∈{IDLE,DONE}. Operands and signedness are captured on that edge.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE/DONE → MUL on a mult/multu start.
  - IDLE/DONE → DIV on a div/divu start with src2_i≠0.
  - IDLE/DONE → DONE on a div/divu start with src2_i=0.
  - Otherwise DONE → IDLE after one cycle.
  - MUL/DIV → DONE when the iteration counter reaches WIDTH-1; exactly WIDTH cycles are spent in MUL/DIV.
- Latency:
  - Start at edge t: done_o=1 during cycle t+WIDTH+1; HI/LO are valid from that cycle.
  - Divide by zero: done_o=1 during cycle t+1.
- Multiply:
  - Shift-add on magnitudes, 2·WIDTH-bit product {HI,LO}.
  - Signed: negate the product if the operand signs differ.
- Divide:
  - Restoring, one quotient bit per cycle, on magnitudes.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
  - Results: LO=quotient, HI=remainder.
  - Signed min/−1: LO=min (two's-complement wrap), HI=0.
  - Divide by zero: LO=all ones, HI=dividend, unsigned and signed alike.
- HI/LO change only on the DONE-entry edge and otherwise hold.
- stall_o = valid_i & ALUOp=010 & funct∈{10,12,18,19,1A,1B} & state∈{MUL,DIV}.
  - A stalled instruction is re-presented by the CPU; it is never captured while busy.
  - Non-MDU instructions never stall.
- mfhi/mflo in the DONE cycle do not stall: hi_o/lo_o already hold the new values.
- Back-to-back: a start in the DONE cycle is accepted; done_o still pulses that cycle.
- Reset (also mid-operation): state=IDLE, counter=0, hi_o=lo_o=0, done_o=0; any in-flight operation is discarded.
- stall_o/ALUCtrl_o are combinational and reflect state=IDLE during reset.

Test Plan:
- Decode sweep: every ALUOp with funct 0x20/22/24/25/2A/10/12/18 plus an illegal funct 0x3F → codes exactly as listed, 1111 for the illegal case, no X outputs.
- multu 0xFFFFFFFF×0xFFFFFFFF at edge t → stall_o on a repeated mfhi during t+1..t+32; done_o at t+33; HI=0xFFFFFFFE, LO=0x00000001.
- mult −7×3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100/7 → LO=14, HI=2.
- div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. divu 5/0 → done_o at t+1, LO=0xFFFFFFFF, HI=5, with no stall cycles.
- rst_i asserted at t+10 of a div → next cycle state IDLE, HI=LO=0, no done_o. A subsequent div 9/4 completes normally: LO=2, HI=1.
- New mult issued in the DONE cycle of a prior div → accepted without stall; the next done_o comes 33 cycles later and the prior div result is visible in between.
